// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and helpers for the nibble-serial ALU sequencer.
//                Defines the sequencer state encoding, the per-command slice
//                control bundle, the nibble-count / index-width helpers and
//                named slice encodings for common logic-mode functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control fields applied unchanged to every nibble of one operation.
  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       ci;
  } alu_ctrl_t;

  // Logic-mode slice encodings (all used with M=1).
  localparam logic [3:0] S_NOT_A  = 4'b0000;
  localparam logic [3:0] S_XOR    = 4'b0110;
  localparam logic [3:0] S_PASS_A = 4'b1111;

  function automatic int nib_count(input int width);
    return width / 4;
  endfunction

  // A single-nibble operation still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_nib_sel.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_nib_sel
//  Description : Combinational selector returning nibble i_idx of both
//                operands. Out-of-range indices return zero.
//  Ports       : i_a, i_b  [WIDTH-1:0]  latched operands
//                i_idx     [IDX_W-1:0]  nibble index
//                o_a, o_b  [3:0]        selected nibbles
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_nib_sel #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 2
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [IDX_W-1:0] i_idx,
  output logic [3:0]       o_a,
  output logic [3:0]       o_b
);

  localparam int NIB = WIDTH / 4;

  // Loop-based mux keeps every part-select constant, so no index can
  // address bits beyond the operand even when WIDTH is not a power of two.
  always_comb begin
    o_a = 4'h0;
    o_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (i_idx == IDX_W'(i)) begin
        o_a = i_a[4*i +: 4];
        o_b = i_b[4*i +: 4];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble_sequencer
//  Description : Runs one WIDTH-bit operation through an external 4-bit ALU
//                slice, one nibble per cycle, LSB nibble first. Nibbles are
//                independent lanes sharing s/M/ci; no carry between nibbles.
//  Ports       : clk, rst_n (async, active-low)
//                req_valid/req_ready, req_s, req_m, req_ci, req_a, req_b
//                alu_s, alu_m, alu_ci, alu_a, alu_b -> slice ; alu_y <- slice
//                rsp_valid/rsp_ready, rsp_y
//  Config      : ALU_SEQ_OVERLAP_EN - accept a new command in DONE on the same
//                edge as the response handoff (one op per NIB+1 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_s,
  input  logic             req_m,
  input  logic             req_ci,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_ci,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [3:0]       alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NIB - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("alu_nibble_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  alu_ctrl_t        r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_y;
  logic             w_accept;
  logic             w_handoff;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;

  alu_seq_nib_sel #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_nib_sel (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_idx (r_idx),
    .o_a   (w_nib_a),
    .o_b   (w_nib_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshakes and slice drive. Slice inputs are held at zero
  // outside RUN so the slice sees no activity between operations.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    w_accept    = 1'b0;
    w_handoff   = 1'b0;
    alu_s       = 4'h0;
    alu_m       = 1'b0;
    alu_ci      = 1'b0;
    alu_a       = 4'h0;
    alu_b       = 4'h0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        alu_s  = r_ctrl.s;
        alu_m  = r_ctrl.m;
        alu_ci = r_ctrl.ci;
        alu_a  = w_nib_a;
        alu_b  = w_nib_b;
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_handoff   = 1'b1;
          w_state_nxt = IDLE;
`ifdef ALU_SEQ_OVERLAP_EN
          req_ready = 1'b1;
          if (req_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = RUN;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= '0;
    end else begin
      if (w_accept) begin
        r_ctrl <= '{s: req_s, m: req_m, ci: req_ci};
        r_a    <= req_a;
        r_b    <= req_b;
        r_idx  <= '0;
      end else if ((r_state == RUN) && (r_idx != c_LAST_IDX)) begin
        r_idx <= r_idx + 1'b1;
      end

      // The previous result stays visible until each nibble is overwritten.
      if (r_state == RUN) begin
        for (int i = 0; i < NIB; i++) begin
          if (r_idx == IDX_W'(i)) begin
            r_rsp_y[4*i +: 4] <= alu_y;
          end
        end
      end

      if ((r_state == RUN) && (r_idx == c_LAST_IDX)) begin
        r_rsp_valid <= 1'b1;
      end else if (w_handoff) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_nibble_sequencer
//  Description : Self-checking bench for alu_nibble_sequencer (WIDTH=16 and
//                WIDTH=4 instances) driving a behavioural 4-bit ALU slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_nibble_sequencer;
  import alu_seq_pkg::*;

  localparam int W   = 16;
  localparam int NIB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic         req_valid, req_ready, req_m, req_ci;
  logic [3:0]   req_s;
  logic [W-1:0] req_a, req_b;
  logic [3:0]   alu_s, alu_a, alu_b, alu_y;
  logic         alu_m, alu_ci;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_y;

  logic       req_valid4, req_ready4, req_m4, req_ci4;
  logic [3:0] req_s4, req_a4, req_b4;
  logic [3:0] alu_s4, alu_a4, alu_b4, alu_y4;
  logic       alu_m4, alu_ci4;
  logic       rsp_valid4, rsp_ready4;
  logic [3:0] rsp_y4;

  // Behavioural 4-bit slice: 16 logic functions in M=1, a few arithmetic ones in M=0.
  function automatic logic [3:0] slice(input logic [3:0] s, input logic m, input logic ci,
                                       input logic [3:0] a, input logic [3:0] b);
    logic [3:0] y;
    y = 4'h0;
    if (m) begin
      case (s)
        4'b0000: y = ~a;
        4'b0001: y = ~(a | b);
        4'b0010: y = ~a & b;
        4'b0011: y = 4'h0;
        4'b0100: y = ~(a & b);
        4'b0101: y = ~b;
        4'b0110: y = a ^ b;
        4'b0111: y = a & ~b;
        4'b1000: y = ~a | b;
        4'b1001: y = ~(a ^ b);
        4'b1010: y = b;
        4'b1011: y = a & b;
        4'b1100: y = 4'hF;
        4'b1101: y = a | ~b;
        4'b1110: y = a | b;
        default: y = a;
      endcase
    end else begin
      case (s)
        4'b1001: y = a + b + {3'b000, ci};
        4'b0110: y = a - b - 4'd1 + {3'b000, ci};
        default: y = a + {3'b000, ci};
      endcase
    end
    return y;
  endfunction

  assign alu_y  = slice(alu_s,  alu_m,  alu_ci,  alu_a,  alu_b);
  assign alu_y4 = slice(alu_s4, alu_m4, alu_ci4, alu_a4, alu_b4);

  alu_nibble_sequencer #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_s(req_s), .req_m(req_m),
    .req_ci(req_ci), .req_a(req_a), .req_b(req_b),
    .alu_s(alu_s), .alu_m(alu_m), .alu_ci(alu_ci), .alu_a(alu_a), .alu_b(alu_b),
    .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y)
  );

  alu_nibble_sequencer #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_s(req_s4), .req_m(req_m4),
    .req_ci(req_ci4), .req_a(req_a4), .req_b(req_b4),
    .alu_s(alu_s4), .alu_m(alu_m4), .alu_ci(alu_ci4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_y(alu_y4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_y(rsp_y4)
  );

  // Reference: whole-word bitwise ops for logic mode; arithmetic ops are
  // evaluated lane by lane modulo 16 since no carry crosses nibbles.
  // op: 0 NOT_A, 1 XOR, 2 PASS_A, 3 AND, 4 OR, 5 ADD, 6 SUB
  function automatic logic [15:0] ref_op(input int op, input logic ci,
                                         input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int la, lb, v;
    r = '0;
    case (op)
      0: r = ~a;
      1: r = a ^ b;
      2: r = a;
      3: r = a & b;
      4: r = a | b;
      default: begin
        for (int i = 0; i < 4; i++) begin
          la = int'((a >> (4 * i)) & 16'h000F);
          lb = int'((b >> (4 * i)) & 16'h000F);
          v  = (op == 5) ? (la + lb + int'(ci)) : (la - lb - 1 + int'(ci) + 16);
          r  = r | (16'(v % 16) << (4 * i));
        end
      end
    endcase
    return r;
  endfunction

  logic [3:0] op_s [7];
  logic       op_m [7];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] y;
    int          k;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // rsp_ready policy: 0 always ready, 1 random, 2 never ready.
  int          rdy_mode = 2;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_y = '0;

  // Monitor: pops the scoreboard on each response handoff.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (req_ready || rsp_valid)
        check("alu_quiet", {18'h0, alu_s, alu_m, alu_ci, alu_a, alu_b}, 32'h0);
`ifndef ALU_SEQ_OVERLAP_EN
      if (rsp_valid) check("req_ready_in_done", {31'h0, req_ready}, 32'h0);
`endif
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 y=%0h expected no response", rsp_y);
        end else begin
          check("latency_cycle", cyc, sb[0].k + NIB);
        end
      end
      if (rsp_valid && prev_valid) check("rsp_y_stable", {16'h0, rsp_y}, {16'h0, prev_y});
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        check("rsp_y", {16'h0, rsp_y}, {16'h0, sb[0].y});
        void'(sb.pop_front());
      end
      prev_valid = rsp_valid;
      prev_y     = rsp_y;
    end
  end

  task automatic issue(input logic [3:0] s, input logic m, input logic ci,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] y_exp, output int k);
    exp_t e;
    @(negedge clk); #1;
    req_s = s; req_m = m; req_ci = ci; req_a = a; req_b = b;
    req_valid = 1'b1;
    k = -1;
    for (int n = 0; n < 200; n++) begin
      if (req_ready) begin
        k = cyc + 1;
        break;
      end
      @(negedge clk); #1;
    end
    if (k < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got req_ready=0 for 200 cycles expected acceptance");
      req_valid = 1'b0;
      return;
    end
    e.y = y_exp;
    e.k = k;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() > 0; n++) @(posedge clk);
    check("drain_empty", sb.size(), 32'h0);
    sb.delete();
  endtask

  task automatic run4(input logic [3:0] s, input logic m, input logic ci,
                      input logic [3:0] a, input logic [3:0] b, input logic [3:0] y_exp);
    @(negedge clk);
    req_s4 = s; req_m4 = m; req_ci4 = ci; req_a4 = a; req_b4 = b;
    req_valid4 = 1'b1;
    #1;
    check("w4_req_ready", {31'h0, req_ready4}, 32'h1);
    @(posedge clk); #1;
    req_valid4 = 1'b0;
    check("w4_run_no_valid", {31'h0, rsp_valid4}, 32'h0);
    check("w4_run_alu_a", {28'h0, alu_a4}, {28'h0, a});
    @(posedge clk); #1;
    check("w4_valid", {31'h0, rsp_valid4}, 32'h1);
    check("w4_y", {28'h0, rsp_y4}, {28'h0, y_exp});
    check("w4_done_alu_a", {28'h0, alu_a4}, 32'h0);
    rsp_ready4 = 1'b1;
    @(posedge clk); #1;
    rsp_ready4 = 1'b0;
    check("w4_released", {31'h0, rsp_valid4}, 32'h0);
  endtask

  initial begin
    int          k1, k2, op;
    logic [15:0] a, b, y16;
    logic        ci;

    op_s = '{4'b0000, 4'b0110, 4'b1111, 4'b1011, 4'b1110, 4'b1001, 4'b0110};
    op_m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_s = '0; req_m = 1'b0; req_ci = 1'b0; req_a = '0; req_b = '0;
    req_valid4 = 1'b0; req_s4 = '0; req_m4 = 1'b0; req_ci4 = 1'b0; req_a4 = '0; req_b4 = '0;
    rsp_ready4 = 1'b0;
    rdy_mode = 2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_low_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rsp_y", {16'h0, rsp_y}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_alu", {18'h0, alu_s, alu_m, alu_ci, alu_a, alu_b}, 32'h0);
    check("rst_w4", {26'h0, rsp_valid4, rsp_y4, req_ready4}, 32'h1);

    // Directed XOR: nibble walk and latency
    rdy_mode = 0;
    a = 16'hA5C3;
    b = 16'h3C0F;
    issue(S_XOR, 1'b1, 1'b0, a, b, 16'h99CC, k1);
    for (int i = 0; i < NIB; i++) begin
      check("run_alu_a", {28'h0, alu_a}, 32'((a >> (4 * i)) & 16'h000F));
      check("run_alu_b", {28'h0, alu_b}, 32'((b >> (4 * i)) & 16'h000F));
      check("run_alu_ctrl", {26'h0, alu_s, alu_m, alu_ci}, {26'h0, S_XOR, 2'b10});
      check("run_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    drain();

    // Back-pressure: result held while rsp_ready is low
    rdy_mode = 2;
    b = 16'($urandom);
    issue(S_NOT_A, 1'b1, 1'b0, 16'h00FF, b, 16'hFF00, k1);
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    check("bp_valid", {31'h0, rsp_valid}, 32'h1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_y", {16'h0, rsp_y}, 32'h0000FF00);
      check("bp_hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    rdy_mode = 0;
    drain();

    // WIDTH=4 instance: single RUN cycle
    run4(S_PASS_A, 1'b1, 1'b0, 4'h7, 4'h2, 4'h7);
    for (int i = 0; i < 4; i++) begin
      op  = $urandom_range(0, 6);
      ci  = 1'($urandom_range(0, 1));
      a   = 16'($urandom_range(0, 15));
      b   = 16'($urandom_range(0, 15));
      y16 = ref_op(op, ci, a, b);
      run4(op_s[op], op_m[op], ci, a[3:0], b[3:0], y16[3:0]);
    end

    // Reset during the second RUN cycle abandons the operation
    a = 16'($urandom);
    issue(S_PASS_A, 1'b1, 1'b0, a, 16'h0000, a, k1);
    @(posedge clk); #1;
    check("abort_alu_a_idx1", {28'h0, alu_a}, 32'((a >> 4) & 16'h000F));
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("abort_rsp_y", {16'h0, rsp_y}, 32'h0);
    check("abort_alu", {18'h0, alu_s, alu_m, alu_ci, alu_a, alu_b}, 32'h0);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    issue(S_XOR, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 16'hF0F0, k1);
    drain();

    // Back-to-back throughput
    issue(S_XOR, 1'b1, 1'b0, 16'hA5C3, 16'h3C0F, 16'h99CC, k1);
    issue(S_XOR, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F, 16'hF0F0, k2);
`ifdef ALU_SEQ_OVERLAP_EN
    check("b2b_gap", k2 - k1, NIB + 1);
`else
    check("b2b_gap", k2 - k1, NIB + 2);
`endif
    drain();

    // Randomized commands with random response back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 6);
      ci = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      issue(op_s[op], op_m[op], ci, a, b, ref_op(op, ci, a, b), k1);
    end
    rdy_mode = 0;
    drain();

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
